adder_result_accumulator: RTL and testbench

ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

---
 rtl/adder_result_accumulator.sv | 90 +++++++++
 tb/tb_adder_result_accumulator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_accumulator.sv
// Sums NUM_SAMPLES 5-bit adder results ({carry_in, sum_in}) into one ACC_W-bit word with valid/ready handshakes.
// Optional macro ACC_SATURATE_EN clamps the total at 2^ACC_W-1 instead of wrapping.
module adder_result_accumulator #(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned ACC_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       count, count_next;
  logic [ACC_W-1:0] acc_q, acc_next;
  logic             ovf_q, ovf_next;
  logic             valid_q;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             last;

  assign in_ready  = (state != DONE);
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, acc_q} + (ACC_W+1)'({carry_in, sum_in});
  // count is 0 in IDLE, so this also covers the single-sample word
  assign last      = (count == 8'(NUM_SAMPLES - 1));
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

  always_comb begin
    state_next = state;
    count_next = count;
    acc_next   = acc_q;
    ovf_next   = ovf_q;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          count_next = count + 8'd1;
          ovf_next   = ovf_q | sum[ACC_W];
`ifdef ACC_SATURATE_EN
          acc_next   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
          acc_next   = sum[ACC_W-1:0];
`endif
          state_next = last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          count_next = '0;
          acc_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        acc_next   = '0;
        ovf_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      acc_q   <= acc_next;
      ovf_q   <= ovf_next;
      valid_q <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: three instances (N=4, N=16, N=1), table-driven words, scoreboard on drain.
module tb_adder_result_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [3:0] sum_in    [3];
  logic       carry_in  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] acc_out   [3];
  logic       overflow  [3];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int k;
    int acc;
    bit ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int              k;
    int              n;
    int              gap;
    logic [15:0][4:0] s;
    int              acc;
    bit              ovf;
  } vec_t;
  vec_t tbl[6];

  adder_result_accumulator #(.NUM_SAMPLES(4), .ACC_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sum_in(sum_in[0]), .carry_in(carry_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .acc_out(acc_out[0]), .overflow(overflow[0]));

  adder_result_accumulator #(.NUM_SAMPLES(16), .ACC_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sum_in(sum_in[1]), .carry_in(carry_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .acc_out(acc_out[1]), .overflow(overflow[1]));

  adder_result_accumulator #(.NUM_SAMPLES(1), .ACC_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sum_in(sum_in[2]), .carry_in(carry_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .acc_out(acc_out[2]), .overflow(overflow[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle a word is presented it must match the head of the scoreboard; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k]) begin
          if (sb.size() == 0 || sb[0].k != k) begin
            chk($sformatf("unexpected_word_dut%0d", k), 1, 0);
          end else begin
            chk($sformatf("acc_out_dut%0d", k), int'(acc_out[k]), sb[0].acc);
            chk($sformatf("overflow_dut%0d", k), int'(overflow[k]), int'(sb[0].ovf));
            if (out_ready[k]) void'(sb.pop_front());
          end
        end
      end
    end
  end

  function automatic vec_t mk(input int k, input int n, input int gap,
                              input int a, input int b, input int c, input int d,
                              input int rest, input int acc, input bit ovf);
    vec_t v;
    v.k = k; v.n = n; v.gap = gap; v.acc = acc; v.ovf = ovf;
    v.s[0] = 5'(a); v.s[1] = 5'(b); v.s[2] = 5'(c); v.s[3] = 5'(d);
    for (int i = 4; i < 16; i++) v.s[i] = 5'(rest);
    return v;
  endfunction

  function automatic exp_t model(input int k, input int n, input logic [15:0][4:0] s);
    exp_t e;
    int   a;
    e.k = k; e.ovf = 1'b0; a = 0;
    for (int i = 0; i < n; i++) begin
      a = a + int'(s[i]);
      if (a > 255) begin
        e.ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        a = 255;
`else
        a = a - 256;
`endif
      end
    end
    e.acc = a;
    return e;
  endfunction

  task automatic send(input int k, input int v);
    bit ok;
    ok = 1'b0;
    in_valid[k] = 1'b1;
    {carry_in[k], sum_in[k]} = 5'(v);
    for (int t = 0; t < 50; t++) begin
      ok = in_ready[k];
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid[k] = 1'b0;
    if (!ok) chk($sformatf("accept_timeout_dut%0d", k), 0, 1);
  endtask

  task automatic send_word(input int k, input int n, input int gap, input logic [15:0][4:0] s);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk($sformatf("no_early_valid_dut%0d", k), int'(out_valid[k]), 0);
      send(k, int'(s[i]));
      if (i != n - 1) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    chk($sformatf("valid_latency_dut%0d", k), int'(out_valid[k]), 1);
    chk($sformatf("ready_low_done_dut%0d", k), int'(in_ready[k]), 0);
  endtask

  task automatic drain(input int k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (!out_valid[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("drain_dut%0d", k), int'(ok), 1);
    chk($sformatf("ready_after_drain_dut%0d", k), int'(in_ready[k]), 1);
  endtask

  initial begin
    logic [15:0][4:0] s;
    exp_t e;

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; sum_in[k] = '0; carry_in[k] = 1'b0; out_ready[k] = 1'b1;
    end
    rst = 1'b1;

    tbl[0] = mk(0, 4, 0, 5, 10, 15, 31, 0, 61, 1'b0);
`ifdef ACC_SATURATE_EN
    tbl[1] = mk(1, 16, 0, 31, 31, 31, 31, 31, 255, 1'b1);
    tbl[3] = mk(1, 16, 0, 16, 16, 16, 16, 16, 255, 1'b1);
`else
    tbl[1] = mk(1, 16, 0, 31, 31, 31, 31, 31, 240, 1'b1);
    tbl[3] = mk(1, 16, 0, 16, 16, 16, 16, 16, 0, 1'b1);
`endif
    tbl[2] = mk(0, 4, 2, 1, 2, 3, 4, 0, 10, 1'b0);
    tbl[4] = mk(1, 16, 0, 0, 17, 17, 17, 17, 255, 1'b0);
    tbl[5] = mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 1'b0);

    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_dut%0d", k), int'(in_ready[k]), 1);
      chk($sformatf("rst_out_valid_dut%0d", k), int'(out_valid[k]), 0);
      chk($sformatf("rst_acc_dut%0d", k), int'(acc_out[k]), 0);
      chk($sformatf("rst_ovf_dut%0d", k), int'(overflow[k]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      e.k = tbl[i].k; e.acc = tbl[i].acc; e.ovf = tbl[i].ovf;
      sb.push_back(e);
      send_word(tbl[i].k, tbl[i].n, tbl[i].gap, tbl[i].s);
      drain(tbl[i].k);
    end

    // Backpressure: word held in DONE while in_valid stays high
    s = '0;
    for (int i = 0; i < 4; i++) s[i] = 5'd3;
    out_ready[0] = 1'b0;
    e.k = 0; e.acc = 12; e.ovf = 1'b0;
    sb.push_back(e);
    send_word(0, 4, 0, s);
    in_valid[0] = 1'b1;
    {carry_in[0], sum_in[0]} = 5'd31;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", int'(in_ready[0]), 0);
      chk("bp_out_valid", int'(out_valid[0]), 1);
      chk("bp_acc_hold", int'(acc_out[0]), 12);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    drain(0);
    for (int i = 0; i < 4; i++) s[i] = 5'(i + 1);
    e.acc = 10;
    sb.push_back(e);
    send_word(0, 4, 0, s);
    drain(0);

    // Asynchronous reset mid-word, then a fresh word
    send(0, 7);
    send(0, 7);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_acc", int'(acc_out[0]), 0);
    chk("mid_rst_valid", int'(out_valid[0]), 0);
    chk("mid_rst_ready", int'(in_ready[0]), 1);
    chk("mid_rst_ovf", int'(overflow[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) s[i] = 5'd1;
    e.acc = 4;
    sb.push_back(e);
    send_word(0, 4, 0, s);
    drain(0);

    // Single-sample words: in_ready toggles under continuous traffic
    e.k = 2; e.acc = 20; e.ovf = 1'b0;
    repeat (3) sb.push_back(e);
    in_valid[2] = 1'b1;
    {carry_in[2], sum_in[2]} = 5'd20;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n1_in_ready_%0d", i), int'(in_ready[2]), i % 2);
      chk($sformatf("n1_out_valid_%0d", i), int'(out_valid[2]), 1 - (i % 2));
    end
    in_valid[2] = 1'b0;

    // Random words against the reference model
    for (int r = 0; r < 6; r++) begin
      int k;
      int n;
      k = r % 2;
      n = (k == 0) ? 4 : 16;
      for (int i = 0; i < 16; i++) s[i] = 5'($urandom_range(0, 31));
      e = model(k, n, s);
      sb.push_back(e);
      send_word(k, n, r % 3, s);
      drain(k);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
